// File: rtl/memory_arb_pkg.sv
// Shared definitions for the weighted round-robin memory arbiter.
//   clog2          : ceiling log2, used to size the grant index
//   DEFAULT_WEIGHT : grants per turn for every master when WEIGHTS is not overridden
//   ST_IDLE/ST_BUSY: arbiter FSM encodings
package memory_arb_pkg;

    localparam int unsigned DEFAULT_WEIGHT = 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/memory_arbitrator_wrr_pick.sv
// Combinational weighted round-robin selection.
//   pend        in  : masters with a request not yet forwarded
//   grant       in  : master holding the current turn
//   credit      in  : extra back-to-back grants left in the current turn
//   weights     in  : packed per-master weights, field 0 counts as 1
//   next_grant  out : master to issue next (meaningless when pend is all zero)
//   next_credit out : credit register value after issuing next_grant
module wrr_pick
    import memory_arb_pkg::*;
#(
    parameter int unsigned MASTERS = 4,
    parameter int unsigned WBITS   = 3,
    parameter int unsigned GBITS   = 2
)(
    input  logic [MASTERS-1:0]       pend,
    input  logic [GBITS-1:0]         grant,
    input  logic [WBITS-1:0]         credit,
    input  logic [MASTERS*WBITS-1:0] weights,
    output logic [GBITS-1:0]         next_grant,
    output logic [WBITS-1:0]         next_credit
);

    logic [MASTERS-1:0] above;
    logic               hi_found;
    logic               lo_found;
    logic [GBITS-1:0]   hi_idx;
    logic [GBITS-1:0]   lo_idx;
    logic [GBITS-1:0]   rot_idx;
    logic [WBITS-1:0]   rot_w;
    logic               own_pend;

    always_comb begin
        above    = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        own_pend = 1'b0;
        rot_w    = '0;

        // Rotation: lowest pending index strictly above grant, else wrap to
        // the lowest pending index overall (which may be grant itself).
        for (int unsigned i = 0; i < MASTERS; i++) begin
            above[i] = (GBITS'(i) > grant);
            if (pend[i] && above[i] && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = GBITS'(i);
            end
            if (pend[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = GBITS'(i);
            end
            if (GBITS'(i) == grant) own_pend = pend[i];
        end
        rot_idx = hi_found ? hi_idx : lo_idx;

        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (GBITS'(i) == rot_idx) rot_w = weights[i*WBITS +: WBITS];
        end
        if (rot_w == '0) rot_w = WBITS'(1);

        if (own_pend && credit != '0) begin
            next_grant  = grant;
            next_credit = credit - WBITS'(1);
        end else begin
            next_grant  = rot_idx;
            next_credit = rot_w - WBITS'(1);
        end
    end

endmodule

// File: rtl/memory_arbitrator_wrr.sv
// Weighted round-robin arbiter: MASTERS toggle-handshake requesters onto one
// toggle-handshake memory slave port.
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   m_req / m_ack  : per-master request/completion toggles (pending while unequal)
//   m_we/m_a/m_d/m_be : per-master packed command fields, stable while pending
//   m_q            : per-master registered read data
//   s_req / s_ack  : slave request/completion toggles (slave idle while equal)
//   s_we/s_a/s_d/s_be : slave command; s_be is all-ones on reads
//   s_q            : slave read data, sampled when s_ack returns
module memory_arbitrator_wrr
    import memory_arb_pkg::*;
#(
    parameter int unsigned MASTERS = 4,
    parameter int unsigned ABITS   = 24,
    parameter int unsigned DBITS   = 32,
    parameter int unsigned WBITS   = 3,
    parameter logic [MASTERS*WBITS-1:0] WEIGHTS = {MASTERS{WBITS'(DEFAULT_WEIGHT)}}
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MASTERS-1:0]         m_req,
    output logic [MASTERS-1:0]         m_ack,
    input  logic [MASTERS-1:0]         m_we,
    input  logic [MASTERS*ABITS-1:0]   m_a,
    input  logic [MASTERS*DBITS-1:0]   m_d,
    input  logic [MASTERS*DBITS/8-1:0] m_be,
    output logic [MASTERS*DBITS-1:0]   m_q,
    output logic                       s_req,
    input  logic                       s_ack,
    output logic                       s_we,
    output logic [ABITS-1:0]           s_a,
    output logic [DBITS-1:0]           s_d,
    output logic [DBITS/8-1:0]         s_be,
    input  logic [DBITS-1:0]           s_q
);

    localparam int unsigned BBITS = DBITS / 8;
    localparam int unsigned GBITS = (clog2(MASTERS) > 0) ? clog2(MASTERS) : 1;
    localparam logic [WBITS-1:0] W0 = WEIGHTS[WBITS-1:0];
    localparam logic [WBITS-1:0] CREDIT_RST = (W0 == '0) ? WBITS'(1) : W0;

    logic               state;
    logic [MASTERS-1:0] issued;
    logic [GBITS-1:0]   grant;
    logic [WBITS-1:0]   credit;

    logic [MASTERS-1:0] pend;
    logic               done;
    logic               issue;
    logic [GBITS-1:0]   pick_grant;
    logic [WBITS-1:0]   pick_credit;
    logic               sel_we;
    logic [ABITS-1:0]   sel_a;
    logic [DBITS-1:0]   sel_d;
    logic [BBITS-1:0]   sel_be;

    assign pend  = m_req ^ issued;
    assign done  = (state == ST_BUSY) && (s_ack == s_req);
    // Completion and the next issue share one edge, so the slave sees no idle cycle.
    assign issue = ((state == ST_IDLE) || done) && (|pend);

    wrr_pick #(
        .MASTERS (MASTERS),
        .WBITS   (WBITS),
        .GBITS   (GBITS)
    ) u_pick (
        .pend        (pend),
        .grant       (grant),
        .credit      (credit),
        .weights     (WEIGHTS),
        .next_grant  (pick_grant),
        .next_credit (pick_credit)
    );

    always_comb begin
        sel_we = 1'b0;
        sel_a  = '0;
        sel_d  = '0;
        sel_be = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (GBITS'(i) == pick_grant) begin
                sel_we = m_we[i];
                sel_a  = m_a[i*ABITS +: ABITS];
                sel_d  = m_d[i*DBITS +: DBITS];
                sel_be = m_be[i*BBITS +: BBITS];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            issued <= '0;
            grant  <= '0;
            credit <= CREDIT_RST;
            m_ack  <= '0;
            m_q    <= '0;
            s_req  <= 1'b0;
            s_we   <= 1'b0;
            s_a    <= '0;
            s_d    <= '0;
            s_be   <= '0;
        end else begin
            // grant still names the master being completed; any reissue below
            // updates it through its own non-blocking assignment.
            if (done) begin
                for (int unsigned i = 0; i < MASTERS; i++) begin
                    if (GBITS'(i) == grant) begin
                        m_ack[i] <= ~m_ack[i];
                        if (!s_we) m_q[i*DBITS +: DBITS] <= s_q;
                    end
                end
            end
            if (issue) begin
                for (int unsigned i = 0; i < MASTERS; i++) begin
                    if (GBITS'(i) == pick_grant) issued[i] <= ~issued[i];
                end
                grant  <= pick_grant;
                credit <= pick_credit;
                s_req  <= ~s_req;
                s_we   <= sel_we;
                s_a    <= sel_a;
                s_d    <= sel_d;
                s_be   <= sel_we ? sel_be : '1;
                state  <= ST_BUSY;
            end else if (done) begin
                state  <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbitrator_wrr.sv
module tb_memory_arbitrator_wrr;

    localparam logic [11:0] WEIGHTS = {3'd0, 3'd1, 3'd1, 3'd3};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   m_req, m_ack, m_we;
    logic [95:0]  m_a;
    logic [127:0] m_d, m_q;
    logic [15:0]  m_be;
    logic         s_req, s_ack, s_we;
    logic [23:0]  s_a;
    logic [31:0]  s_d, s_q;
    logic [3:0]   s_be;

    memory_arbitrator_wrr #(
        .MASTERS (4),
        .ABITS   (24),
        .DBITS   (32),
        .WBITS   (3),
        .WEIGHTS (WEIGHTS)
    ) dut (
        .clk (clk), .reset (reset),
        .m_req (m_req), .m_ack (m_ack), .m_we (m_we), .m_a (m_a), .m_d (m_d),
        .m_be (m_be), .m_q (m_q),
        .s_req (s_req), .s_ack (s_ack), .s_we (s_we), .s_a (s_a), .s_d (s_d),
        .s_be (s_be), .s_q (s_q)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [23:0] a; logic [31:0] d; logic [3:0] be; } txn_t;
    typedef struct { int unsigned cyc; logic we; logic [23:0] a; logic [31:0] d; logic [3:0] be; } iss_t;
    typedef struct { int unsigned cyc; int unsigned idx; logic [31:0] q; } ack_t;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // reference model state: a turn belongs to one master and carries a
    // number of extra grants it may still take
    txn_t        req_txn [4];
    bit          req_pend[4];
    logic [31:0] exp_q   [4];
    bit          m_busy;
    int unsigned m_cur, m_left;
    logic        m_cur_we;
    int unsigned cyc = 0;
    int unsigned resp_seen;
    iss_t        iss_q[$];
    ack_t        ack_q[$];
    int unsigned seen_g[$];

    // slave state
    bit          slave_hold = 0;
    bit          sl_force = 0;
    logic [31:0] sl_force_q = '0;
    bit          sl_active = 0;
    int unsigned sl_wait = 0;
    int unsigned slave_resp_cnt = 0;
    logic [31:0] slave_last_q = '0;

    // monitor state
    logic        prev_sreq;
    logic [3:0]  prev_ack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic int unsigned weff(input int unsigned i);
        logic [11:0] sh;
        sh = WEIGHTS >> (3 * i);
        return (sh[2:0] == 3'd0) ? 1 : 32'(sh[2:0]);
    endfunction

    function automatic bit any_pend();
        return req_pend[0] | req_pend[1] | req_pend[2] | req_pend[3];
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_cur  = 0;
        m_left = weff(0);
        resp_seen = slave_resp_cnt;
        for (int i = 0; i < 4; i++) begin
            req_pend[i] = 0;
            exp_q[i] = '0;
        end
        iss_q.delete();
        ack_q.delete();
        seen_g.delete();
        prev_sreq = 1'b0;
        prev_ack  = '0;
    endtask

    task automatic model_step();
        int unsigned g;
        cyc++;
        if (m_busy && resp_seen != slave_resp_cnt) begin
            resp_seen = slave_resp_cnt;
            if (!m_cur_we) exp_q[m_cur] = slave_last_q;
            ack_q.push_back('{cyc, m_cur, exp_q[m_cur]});
            m_busy = 0;
        end
        if (!m_busy && any_pend()) begin
            g = m_cur;
            if (req_pend[m_cur] && m_left > 0) begin
                m_left--;
            end else begin
                for (int unsigned k = 1; k <= 4; k++) begin
                    if (req_pend[(m_cur + k) % 4]) begin
                        g = (m_cur + k) % 4;
                        break;
                    end
                end
                m_cur  = g;
                m_left = weff(g) - 1;
            end
            iss_q.push_back('{cyc, req_txn[g].we, req_txn[g].a, req_txn[g].d,
                              req_txn[g].we ? req_txn[g].be : 4'hF});
            req_pend[g] = 0;
            m_cur_we = req_txn[g].we;
            m_busy = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!reset) model_step();
    end

    // slave: answers each s_req toggle after 0..3 cycles with random data
    initial forever begin
        @(negedge clk);
        if (reset) begin
            s_ack = 1'b0;
            sl_active = 0;
        end else begin
            if (!sl_active && s_req != s_ack) begin
                sl_active = 1;
                sl_wait = $urandom_range(0, 3);
            end
            if (sl_active && !slave_hold) begin
                if (sl_wait == 0) begin
                    s_q = sl_force ? sl_force_q : $urandom;
                    slave_last_q = s_q;
                    slave_resp_cnt++;
                    s_ack = ~s_ack;
                    sl_active = 0;
                end else begin
                    sl_wait--;
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a toggle
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (s_req !== prev_sreq) begin
                prev_sreq = s_req;
                if (iss_q.size() == 0) begin
                    fail("unexpected_issue", $sformatf("s_a=%0h with nothing expected", s_a));
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("issue_cycle", 64'(cyc), 64'(e.cyc));
                    check("s_we", s_we, e.we);
                    check("s_a", s_a, e.a);
                    if (e.we) check("s_d", s_d, e.d);
                    check("s_be", s_be, e.be);
                    seen_g.push_back(32'(s_a[23:20]));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_ack[i] !== prev_ack[i]) begin
                    prev_ack[i] = m_ack[i];
                    if (ack_q.size() == 0) begin
                        fail("unexpected_ack", $sformatf("m_ack[%0d] toggled", i));
                    end else begin
                        ack_t e;
                        e = ack_q.pop_front();
                        check("ack_master", 64'(i), 64'(e.idx));
                        check("ack_cycle", 64'(cyc), 64'(e.cyc));
                        check("m_q", m_q[i*32 +: 32], e.q);
                    end
                end
            end
        end
    end

    task automatic issue(input int unsigned i, input logic we, input logic [23:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        assert (m_req[i] == m_ack[i]) else $error("master %0d re-toggled m_req before m_ack", i);
        m_we[i] = we;
        m_a[i*24 +: 24] = a;
        m_d[i*32 +: 32] = d;
        m_be[i*4 +: 4] = be;
        req_txn[i] = '{we, a, d, be};
        req_pend[i] = 1;
        m_req[i] = ~m_req[i];
    endtask

    task automatic wait_idle(input int unsigned budget);
        for (int unsigned c = 0; c < budget; c++) begin
            @(negedge clk);
            if (m_ack == m_req && !m_busy && !any_pend()) return;
        end
        fail("idle_timeout", $sformatf("m_req=%0h m_ack=%0h", m_req, m_ack));
    endtask

    // all masters in mask request on the same edge; addresses carry the master index
    task automatic group(input logic [3:0] mask);
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) issue(i, 1'($urandom), {4'(i), 20'($urandom)}, $urandom, 4'($urandom));
        end
        wait_idle(200);
    endtask

    task automatic check_order(input string name, input int n, input int unsigned a,
                               input int unsigned b, input int unsigned c, input int unsigned d);
        int unsigned e[4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        check({name, "_len"}, 64'(seen_g.size()), 64'(n));
        for (int k = 0; k < n && k < seen_g.size(); k++) check(name, 64'(seen_g[k]), 64'(e[k]));
        seen_g.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_ack"}, m_ack, 4'h0);
        check({tag, "_m_q"},   m_q, 128'h0);
        check({tag, "_s_req"}, s_req, 1'b0);
        check({tag, "_s_we"},  s_we, 1'b0);
        check({tag, "_s_a"},   s_a, 24'h0);
        check({tag, "_s_d"},   s_d, 32'h0);
        check({tag, "_s_be"},  s_be, 4'h0);
    endtask

    task automatic rand_master(input int unsigned i, input int unsigned n);
        int unsigned c;
        for (int unsigned k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            c = 0;
            while (m_ack[i] != m_req[i] && c < 400) begin
                @(negedge clk);
                c++;
            end
            if (c >= 400) begin
                fail("rand_ack_timeout", $sformatf("master %0d", i));
                return;
            end
            issue(i, 1'($urandom), {4'(i), 20'($urandom)}, $urandom, 4'($urandom));
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_req = '0; m_we = '0; m_a = '0; m_d = '0; m_be = '0; s_q = '0; s_ack = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // single read: s_a one clock after the toggle, data returned to m_q[2]
        sl_force = 1; sl_force_q = 32'hDEADBEEF;
        issue(2, 1'b0, 24'h000100, 32'h0, 4'h0);
        @(posedge clk); #1;
        check("read_s_req", s_req, 1'b1);
        check("read_s_a", s_a, 24'h000100);
        check("read_s_be", s_be, 4'hF);
        wait_idle(50);
        check("read_m_ack2", m_ack[2], 1'b1);
        check("read_m_q2", m_q[95:64], 32'hDEADBEEF);

        // write with partial byte enables leaves the master's m_q untouched
        sl_force_q = 32'hCAFEF00D;
        @(negedge clk);
        issue(1, 1'b0, 24'h000200, 32'h0, 4'h0);
        wait_idle(50);
        sl_force = 0;
        issue(1, 1'b1, 24'h000204, 32'h11223344, 4'b0101);
        @(posedge clk); #1;
        check("write_s_we", s_we, 1'b1);
        check("write_s_be", s_be, 4'b0101);
        check("write_s_d", s_d, 32'h11223344);
        wait_idle(50);
        check("write_m_q1_kept", m_q[63:32], 32'hCAFEF00D);

        // all four pending with grant at 3: strict rotation
        group(4'b1000);
        seen_g.delete();
        group(4'b1111);
        check_order("rotate_all", 4, 0, 1, 2, 3);

        // master 0 weight 3: a fresh turn keeps the grant over a waiting master 1
        group(4'b0001);
        seen_g.delete();
        group(4'b0011);
        check_order("weight_stay", 2, 0, 1, 0, 0);
        group(4'b0001);
        group(4'b0001);
        group(4'b0001);
        seen_g.delete();
        group(4'b0011);
        check_order("weight_spent", 2, 1, 0, 0, 0);

        // master 3 weight field 0 acts as a single grant per turn
        group(4'b1000);
        seen_g.delete();
        group(4'b1001);
        check_order("weight_zero", 2, 0, 3, 0, 0);

        // random traffic from all masters
        fork
            rand_master(0, 25);
            rand_master(1, 25);
            rand_master(2, 25);
            rand_master(3, 25);
        join
        wait_idle(500);

        // reset while the slave cycle is outstanding
        slave_hold = 1;
        @(negedge clk);
        issue(2, 1'b0, 24'h2ABCDE, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        m_req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        slave_hold = 0;
        reset = 1'b0;
        group(4'b0011);
        check_order("after_reset", 2, 0, 1, 0, 0);
        group(4'b0100);

        check("iss_queue_empty", 64'(iss_q.size()), 64'd0);
        check("ack_queue_empty", 64'(ack_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
